// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter and its access checker.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic [2:0] WM_BS = 3'b000;
  localparam logic [2:0] WM_HS = 3'b001;
  localparam logic [2:0] WM_W  = 3'b010;
  localparam logic [2:0] WM_BU = 3'b011;
  localparam logic [2:0] WM_HU = 3'b100;

  localparam logic PORT_C = 1'b0;
  localparam logic PORT_D = 1'b1;

  // Reads always fetch a full word; undefined write modes are sized as a word
  // but get flagged separately.
  function automatic logic [2:0] access_size(input logic we, input logic [2:0] wmode);
    if (!we) return 3'd4;
    case (wmode)
      WM_BS, WM_BU: return 3'd1;
      WM_HS, WM_HU: return 3'd2;
      default:      return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/dmem_access_check.sv
// Combinational alignment / range / mode check for one data-memory access.
module dmem_access_check
  import dmem_arb_pkg::*;
#(
  parameter int DMEM_BYTES = 1024,
  parameter int ADDR_W     = 32
) (
  input  logic              we_i,
  input  logic [2:0]        wmode_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              err_o
);

  logic [2:0]      size;
  logic [ADDR_W:0] end_addr;
  logic            bad_mode, misal, oor;

  always_comb begin
    size     = access_size(we_i, wmode_i);
    bad_mode = we_i && (wmode_i > WM_HU);
    misal    = ((size == 3'd2) && addr_i[0]) || ((size == 3'd4) && (addr_i[1:0] != 2'b00));
    // One extra bit so an access near the top of the address space cannot wrap.
    end_addr = {1'b0, addr_i} + (ADDR_W+1)'(size);
    oor      = end_addr > (ADDR_W+1)'(DMEM_BYTES);
    err_o    = bad_mode || misal || oor;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port (core C / debug D) arbiter and IDLE->ACCESS->RESP sequencer for the
// single-port data memory. Define DMEM_ARB_FIXED_PRIO_EN for fixed C-first priority.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DMEM_BYTES = 1024,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req_valid,
  output logic              c_req_ready,
  input  logic              c_req_we,
  input  logic [2:0]        c_req_wmode,
  input  logic [ADDR_W-1:0] c_req_addr,
  input  logic [31:0]       c_req_wdata,
  output logic              c_rsp_valid,
  output logic [31:0]       c_rsp_rdata,
  output logic              c_rsp_err,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic              d_req_we,
  input  logic [2:0]        d_req_wmode,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [31:0]       d_req_wdata,
  output logic              d_rsp_valid,
  output logic [31:0]       d_rsp_rdata,
  output logic              d_rsp_err,
  output logic              mem_we,
  output logic [2:0]        mem_wmode,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_e            state_q, state_d;
  logic              port_q, port_d;
  logic              we_q, we_d;
  logic [2:0]        wmode_q, wmode_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;

  logic              win, grant;
  logic              sel_we;
  logic [2:0]        sel_wmode;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic              sel_err;
  logic              in_acc, in_rsp;
  logic [31:0]       rsp_rdata;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  always_comb win = c_req_valid ? PORT_C : PORT_D;
`else
  logic rr_last_q, rr_last_d;

  always_comb begin
    if (c_req_valid && d_req_valid) win = ~rr_last_q;
    else                            win = c_req_valid ? PORT_C : PORT_D;
  end
`endif

  // Ready is gated by reset so nothing is accepted while reset is held.
  assign grant = (state_q == IDLE) && (c_req_valid || d_req_valid) && rst;

  always_comb begin
    sel_we    = c_req_we;
    sel_wmode = c_req_wmode;
    sel_addr  = c_req_addr;
    sel_wdata = c_req_wdata;
    if (win == PORT_D) begin
      sel_we    = d_req_we;
      sel_wmode = d_req_wmode;
      sel_addr  = d_req_addr;
      sel_wdata = d_req_wdata;
    end
  end

  dmem_access_check #(
    .DMEM_BYTES(DMEM_BYTES),
    .ADDR_W    (ADDR_W)
  ) u_check (
    .we_i   (sel_we),
    .wmode_i(sel_wmode),
    .addr_i (sel_addr),
    .err_o  (sel_err)
  );

  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    we_d    = we_q;
    wmode_d = wmode_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
`ifndef DMEM_ARB_FIXED_PRIO_EN
    rr_last_d = rr_last_q;
`endif
    case (state_q)
      IDLE: if (grant) begin
        state_d = ACCESS;
        port_d  = win;
        we_d    = sel_we;
        wmode_d = sel_wmode;
        addr_d  = sel_addr;
        wdata_d = sel_wdata;
        err_d   = sel_err;
`ifndef DMEM_ARB_FIXED_PRIO_EN
        rr_last_d = win;
`endif
      end
      ACCESS:  state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      port_q  <= PORT_C;
      we_q    <= 1'b0;
      wmode_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      rr_last_q <= PORT_D;
`endif
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
      we_q    <= we_d;
      wmode_q <= wmode_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      rr_last_q <= rr_last_d;
`endif
    end
  end

  assign c_req_ready = grant && (win == PORT_C);
  assign d_req_ready = grant && (win == PORT_D);

  assign in_acc = (state_q == ACCESS);
  assign in_rsp = (state_q == RESP);

  // Outside ACCESS the memory sees address 0 with we=0, i.e. a harmless read.
  assign mem_we    = in_acc && we_q && !err_q;
  assign mem_wmode = in_acc ? wmode_q : 3'b000;
  assign mem_addr  = (in_acc && !err_q) ? addr_q : '0;
  assign mem_wdata = in_acc ? wdata_q : 32'h0;

  assign rsp_rdata   = (in_rsp && !we_q && !err_q) ? mem_rdata : 32'h0;
  assign c_rsp_valid = in_rsp && (port_q == PORT_C);
  assign d_rsp_valid = in_rsp && (port_q == PORT_D);
  assign c_rsp_rdata = c_rsp_valid ? rsp_rdata : 32'h0;
  assign d_rsp_rdata = d_rsp_valid ? rsp_rdata : 32'h0;
  assign c_rsp_err   = c_rsp_valid && err_q;
  assign d_rsp_err   = d_rsp_valid && err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-addressed registered-read memory model.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_req_valid, c_req_we, d_req_valid, d_req_we;
  logic [2:0]  c_req_wmode, d_req_wmode;
  logic [31:0] c_req_addr, c_req_wdata, d_req_addr, d_req_wdata;
  logic        c_req_ready, d_req_ready;
  logic        c_rsp_valid, c_rsp_err, d_rsp_valid, d_rsp_err;
  logic [31:0] c_rsp_rdata, d_rsp_rdata;
  logic        mem_we;
  logic [2:0]  mem_wmode;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic [7:0]  mem [1024];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DMEM_BYTES(1024), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .c_req_valid(c_req_valid), .c_req_ready(c_req_ready), .c_req_we(c_req_we),
    .c_req_wmode(c_req_wmode), .c_req_addr(c_req_addr), .c_req_wdata(c_req_wdata),
    .c_rsp_valid(c_rsp_valid), .c_rsp_rdata(c_rsp_rdata), .c_rsp_err(c_rsp_err),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
    .d_req_wmode(d_req_wmode), .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
    .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata), .d_rsp_err(d_rsp_err),
    .mem_we(mem_we), .mem_wmode(mem_wmode), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic int bi(input logic [9:0] base, input int k);
    return int'(base + 10'(k));
  endfunction

  always @(posedge clk) begin
    if (mem_we) begin
      mem[bi(mem_addr[9:0], 0)] <= mem_wdata[7:0];
      if (mem_wmode == WM_HS || mem_wmode == WM_HU || mem_wmode == WM_W)
        mem[bi(mem_addr[9:0], 1)] <= mem_wdata[15:8];
      if (mem_wmode == WM_W) begin
        mem[bi(mem_addr[9:0], 2)] <= mem_wdata[23:16];
        mem[bi(mem_addr[9:0], 3)] <= mem_wdata[31:24];
      end
    end else begin
      mem_rdata <= {mem[bi(mem_addr[9:0], 3)], mem[bi(mem_addr[9:0], 2)],
                    mem[bi(mem_addr[9:0], 1)], mem[bi(mem_addr[9:0], 0)]};
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic set_req(input logic p, input logic we, input logic [2:0] wm,
                         input logic [31:0] addr, input logic [31:0] wd);
    if (p == PORT_C) begin
      c_req_valid = 1'b1; c_req_we = we; c_req_wmode = wm; c_req_addr = addr; c_req_wdata = wd;
    end else begin
      d_req_valid = 1'b1; d_req_we = we; d_req_wmode = wm; d_req_addr = addr; d_req_wdata = wd;
    end
  endtask

  task automatic clr_req(input logic p);
    if (p == PORT_C) c_req_valid = 1'b0;
    else             d_req_valid = 1'b0;
  endtask

  // One transaction on a single port: ready at N, ACCESS at N+1, response at N+2.
  task automatic xact(input string tag, input logic p, input logic we, input logic [2:0] wm,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err);
    logic got;
    got = 1'b0;
    @(posedge clk); #1;
    set_req(p, we, wm, addr, wd);
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = (p == PORT_D) ? d_req_ready : c_req_ready;
    end
    chk({tag, ".rdy"}, 32'(got), 32'd1);
    if (!got) begin
      clr_req(p);
      return;
    end
    chk({tag, ".rdy_other"}, 32'((p == PORT_D) ? c_req_ready : d_req_ready), 32'd0);
    @(posedge clk); #1;
    clr_req(p);
    chk({tag, ".mem_we"}, 32'(mem_we), 32'(we && !exp_err));
    chk({tag, ".mem_addr"}, mem_addr, exp_err ? 32'h0 : addr);
    @(negedge clk);
    chk({tag, ".early_rsp"}, 32'(c_rsp_valid | d_rsp_valid), 32'd0);
    @(negedge clk);
    chk({tag, ".rsp_c"}, 32'(c_rsp_valid), 32'(p == PORT_C));
    chk({tag, ".rsp_d"}, 32'(d_rsp_valid), 32'(p == PORT_D));
    chk({tag, ".rdata"}, (p == PORT_D) ? d_rsp_rdata : c_rsp_rdata, exp_rd);
    chk({tag, ".err"}, 32'((p == PORT_D) ? d_rsp_err : c_rsp_err), 32'(exp_err));
  endtask

  // Both ports contend with reads of 0x10; check grant order and response routing.
  task automatic contend(input int lim_c, input int lim_d);
    int  cnt_c, cnt_d, exp_p;
    logic got, gp;
    cnt_c = 0; cnt_d = 0;
    @(posedge clk); #1;
    set_req(PORT_C, 1'b0, WM_W, 32'h10, 32'h0);
    set_req(PORT_D, 1'b0, WM_W, 32'h10, 32'h0);
    for (int g = 0; g < lim_c + lim_d; g++) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
      exp_p = (g < lim_c) ? 0 : 1;
`else
      exp_p = g % 2;
`endif
      got = 1'b0;
      for (int n = 0; n < 20 && !got; n++) begin
        @(negedge clk);
        got = c_req_ready | d_req_ready;
      end
      chk("arb.rdy", 32'(got), 32'd1);
      if (!got) break;
      chk("arb.onehot", 32'(c_req_ready & d_req_ready), 32'd0);
      gp = d_req_ready;
      chk("arb.port", 32'(gp), 32'(exp_p));
      if (gp) cnt_d++; else cnt_c++;
      @(posedge clk); #1;
      if (cnt_c >= lim_c) clr_req(PORT_C);
      if (cnt_d >= lim_d) clr_req(PORT_D);
      @(negedge clk);
      @(negedge clk);
      chk("arb.rsp_c", 32'(c_rsp_valid), 32'(!gp));
      chk("arb.rsp_d", 32'(d_rsp_valid), 32'(gp));
      chk("arb.rdata", gp ? d_rsp_rdata : c_rsp_rdata, 32'hDEADBEEF);
    end
    clr_req(PORT_C);
    clr_req(PORT_D);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
    rst = 1'b0;
    c_req_valid = 1'b0; c_req_we = 1'b0; c_req_wmode = '0; c_req_addr = '0; c_req_wdata = '0;
    d_req_valid = 1'b0; d_req_we = 1'b0; d_req_wmode = '0; d_req_addr = '0; d_req_wdata = '0;
    set_req(PORT_C, 1'b1, WM_W, 32'h10, 32'h12345678);
    #12;
    chk("rst.c_ready", 32'(c_req_ready), 32'd0);
    chk("rst.mem_we", 32'(mem_we), 32'd0);
    chk("rst.mem_addr", mem_addr, 32'h0);
    chk("rst.rsp", 32'(c_rsp_valid | d_rsp_valid), 32'd0);
    clr_req(PORT_C);
    #11 rst = 1'b1;

    xact("wr10", PORT_C, 1'b1, WM_W, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    xact("rd10", PORT_C, 1'b0, WM_W, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    xact("rd10d", PORT_D, 1'b0, WM_W, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

`ifdef DMEM_ARB_FIXED_PRIO_EN
    contend(3, 1);
`else
    contend(4, 4);
`endif

    xact("wr20", PORT_D, 1'b1, WM_W, 32'h20, 32'h11223344, 32'h0, 1'b0);
    xact("half21", PORT_C, 1'b1, WM_HU, 32'h21, 32'hAAAA5555, 32'h0, 1'b1);
    xact("word22", PORT_C, 1'b1, WM_W, 32'h22, 32'hAAAA5555, 32'h0, 1'b1);
    xact("mode5", PORT_C, 1'b1, 3'b101, 32'h20, 32'hAAAA5555, 32'h0, 1'b1);
    xact("rd20", PORT_C, 1'b0, WM_W, 32'h20, 32'h0, 32'h11223344, 1'b0);
    xact("word1021", PORT_C, 1'b1, WM_W, 32'd1021, 32'hFFFFFFFF, 32'h0, 1'b1);
    xact("byte1023", PORT_C, 1'b1, WM_BU, 32'd1023, 32'h0000005A, 32'h0, 1'b0);
    xact("rd1020", PORT_D, 1'b0, WM_W, 32'd1020, 32'h0, 32'h5A000000, 1'b0);
    xact("rd1021", PORT_D, 1'b0, WM_W, 32'd1021, 32'h0, 32'h0, 1'b1);
    xact("rd1024", PORT_D, 1'b0, WM_W, 32'd1024, 32'h0, 32'h0, 1'b1);
    xact("wrtop", PORT_C, 1'b1, WM_W, 32'hFFFFFFFC, 32'h1, 32'h0, 1'b1);

    // Reset asserted while a write is in ACCESS.
    begin
      logic got;
      got = 1'b0;
      @(posedge clk); #1;
      set_req(PORT_C, 1'b1, WM_W, 32'h40, 32'hCAFEF00D);
      for (int n = 0; n < 20 && !got; n++) begin
        @(negedge clk);
        got = c_req_ready;
      end
      chk("rstacc.rdy", 32'(got), 32'd1);
      @(posedge clk); #1;
      clr_req(PORT_C);
      chk("rstacc.we_before", 32'(mem_we), 32'(got));
      rst = 1'b0;
      #1;
      chk("rstacc.mem_we", 32'(mem_we), 32'd0);
      chk("rstacc.mem_addr", mem_addr, 32'h0);
      chk("rstacc.mem_wdata", mem_wdata, 32'h0);
      chk("rstacc.rsp", 32'(c_rsp_valid | d_rsp_valid), 32'd0);
      @(posedge clk); #2;
      rst = 1'b1;
      for (int n = 0; n < 3; n++) begin
        @(negedge clk);
        chk("rstacc.no_rsp", 32'(c_rsp_valid | d_rsp_valid), 32'd0);
      end
    end
    xact("after_rst", PORT_C, 1'b0, WM_W, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
